// File: rtl/bcnn_pkg.sv
// Shared types and constants for the BCNN layer pipeline.
// Holds the pixel format and the maxpool sequencer state encoding.
package bcnn_pkg;

  localparam int FRAC_BITS = 8;

  typedef logic [11:0] pix_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FETCH,
    ST_DRAIN,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } mpc_state_e;

endpackage

// File: rtl/win_addr_gen.sv
// Window walker for 2x2 pooling: column/row counters, running row base,
// 4-step in-window address sequencer and wrap flags.
module win_addr_gen
  import bcnn_pkg::*;
#(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int RADDR_W = 10,
  parameter int WADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               step_en,
  input  logic               adv,
  output logic [RADDR_W-1:0] addr,
  output logic [1:0]         step,
  output logic               last_step,
  output logic               last_win,
  output logic [WADDR_W-1:0] widx
);

  localparam int NC = IMG_W / 2;
  localparam int NR = IMG_H / 2;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [RADDR_W-1:0] ROW_STEP = RADDR_W'(2 * IMG_W);
  localparam logic [RADDR_W-1:0] W_OFF    = RADDR_W'(IMG_W);

  logic [CW-1:0]      col_reg;
  logic [RW-1:0]      row_reg;
  logic [RADDR_W-1:0] row_base_reg;
  logic [RADDR_W-1:0] col_off_reg;
  logic [1:0]         step_reg;
  logic [WADDR_W-1:0] widx_reg;
  logic               last_col;
  logic               last_row;

  assign last_col = (col_reg == CW'(NC - 1));
  assign last_row = (row_reg == RW'(NR - 1));

  always_ff @(posedge clk) begin
    if (!rst || init) begin
      col_reg      <= '0;
      row_reg      <= '0;
      row_base_reg <= '0;
      col_off_reg  <= '0;
      step_reg     <= '0;
      widx_reg     <= '0;
    end else begin
      if (step_en) step_reg <= step_reg + 2'd1;
      if (adv) begin
        widx_reg <= widx_reg + WADDR_W'(1);
        if (last_col) begin
          col_reg     <= '0;
          col_off_reg <= '0;
          if (last_row) begin
            row_reg      <= '0;
            row_base_reg <= '0;
          end else begin
            row_reg      <= row_reg + RW'(1);
            row_base_reg <= row_base_reg + ROW_STEP;
          end
        end else begin
          col_reg     <= col_reg + CW'(1);
          col_off_reg <= col_off_reg + RADDR_W'(2);
        end
      end
    end
  end

  // step order: top-left, top-right, bottom-left, bottom-right
  assign addr      = row_base_reg + col_off_reg + (step_reg[1] ? W_OFF : '0) + RADDR_W'(step_reg[0]);
  assign step      = step_reg;
  assign last_step = (step_reg == 2'd3);
  assign last_win  = last_col && last_row;
  assign widx      = widx_reg;

endmodule

// File: rtl/maxpool_ctrl.sv
// Frame sequencer for the 2x2 maxpool unit: fetches each window, streams it
// into maxpool, waits for the result and writes it to the pooled-map buffer.
module maxpool_ctrl
  import bcnn_pkg::*;
#(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int DATA_W  = 12,
  parameter int RADDR_W = $clog2(IMG_W * IMG_H),
  parameter int WADDR_W = $clog2((IMG_W / 2) * (IMG_H / 2))
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               rd_en,
  output logic [RADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               mp_clr,
  output logic [DATA_W-1:0]  mp_data,
  output logic               mp_end,
  input  logic               mp_finish,
  input  logic [DATA_W-1:0]  mp_out,
  output logic               wr_en,
  output logic [WADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data
);

  mpc_state_e         state_reg, state_next;
  logic [DATA_W-1:0]  result_reg;
  logic               err_reg;
  logic [RADDR_W-1:0] gen_addr;
  logic [1:0]         gen_step;
  logic               last_step;
  logic               last_win;
  logic [WADDR_W-1:0] gen_widx;
  logic               mp_valid;

  win_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .RADDR_W(RADDR_W),
    .WADDR_W(WADDR_W)
  ) u_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (state_reg == ST_CLR),
    .step_en  (state_reg == ST_FETCH),
    .adv      (state_reg == ST_WRITE),
    .addr     (gen_addr),
    .step     (gen_step),
    .last_step(last_step),
    .last_win (last_win),
    .widx     (gen_widx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_WAIT && mp_finish) result_reg <= mp_out;
      // an accepted start wins over a stray finish in the same cycle
      if (state_reg == ST_IDLE && start) err_reg <= 1'b0;
      else if (mp_finish && state_reg != ST_WAIT) err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    mp_clr     = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CLR;
      ST_CLR: begin
        mp_clr     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en = 1'b1;
        if (last_step) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_WAIT;
      ST_WAIT:  if (mp_finish) state_next = ST_WRITE;
      ST_WRITE: begin
        wr_en      = 1'b1;
        state_next = last_win ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // read data lags its address by one cycle, so pixels land on FETCH 2..4 and DRAIN
  assign mp_valid = (state_reg == ST_FETCH && gen_step != 2'd0) || state_reg == ST_DRAIN;
  assign mp_data  = mp_valid ? rd_data : '0;
  assign mp_end   = (state_reg == ST_DRAIN);
  assign rd_addr  = rd_en ? gen_addr : '0;
  assign wr_addr  = wr_en ? gen_widx : '0;
  assign wr_data  = wr_en ? result_reg : '0;
  assign busy     = (state_reg != ST_IDLE);
  assign err      = err_reg;

endmodule

// File: doc/maxpool_ctrl.md
# maxpool_ctrl

Frame-level sequencer for the 2×2 `maxpool` unit. On `start` it scans an IMG_H×IMG_W Q4.8 feature map in an external single-port read memory, window by window. For each window it streams the four pixels into `maxpool`, waits for `finish`, and writes the pooled result to a sequential output buffer. It sits between the conv-output feature-map RAM and the pooled-map RAM in the BCNN layer pipeline.

## Interface
- `IMG_W`, default 28: input map width, ≥2.
- `IMG_H`, default 28: input map height, ≥2.
- `DATA_W`, default 12: pixel width, Q4.8.
- `RADDR_W`, default `$clog2(IMG_W*IMG_H)`: input address width.
- `WADDR_W`, default `$clog2((IMG_W/2)*(IMG_H/2))`: output address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-low.
- `start` in 1: one-cycle frame start request.
- `busy` out 1: high from start acceptance to `done`.
- `done` out 1: one-cycle pulse after the last write.
- `err` out 1: sticky, set on unexpected `mp_finish`; cleared by reset or an accepted `start`.
- `rd_en` out 1: input memory read strobe.
- `rd_addr` out RADDR_W: input memory address.
- `rd_data` in DATA_W: read data, valid 1 cycle after `rd_en`.
- `mp_clr` out 1: one-cycle clear pulse to `maxpool` at frame start.
- `mp_data` out DATA_W: maxpool `data_in`.
- `mp_end` out 1: maxpool `end_data`, high with the 4th pixel.
- `mp_finish` in 1: maxpool `finish`.
- `mp_out` in DATA_W: maxpool result, sampled when `mp_finish`=1.
- `wr_en` out 1: output memory write strobe.
- `wr_addr` out WADDR_W: output address.
- `wr_data` out DATA_W: pooled value.

## Operation
- Reset (`rst`=0 at a clk edge): state←IDLE. Counters zero. All outputs 0, including `err`. This applies mid-frame: no further reads or writes are issued, and an in-flight `mp_finish` is ignored.
- States: IDLE → CLR → FETCH → DRAIN → WAIT → WRITE → (FETCH | DONE) → IDLE.
- IDLE: `start`=1 is accepted. `busy`←1, `err`←0, go to CLR.
- CLR: one cycle with `mp_clr`=1, then FETCH. The window pointer is at row 0, col 0 and `wr_addr` is 0.
- FETCH: 4 consecutive cycles with `rd_en`=1. Addresses in order: base, base+1, base+IMG_W, base+IMG_W+1, where base = 2r·IMG_W + 2c. The row base is kept in a register incremented by 2·IMG_W, so no multiplier is needed.
- Data forwarding: `mp_data` = registered `rd_data` of the previous cycle. It is qualified by the FETCH cycles 2–4 and the DRAIN cycle. `mp_end`=1 only with the 4th pixel, which is the DRAIN cycle.
- WAIT: hold until `mp_finish`=1. Latch `mp_out` and go to WRITE. There is no timeout.
- WRITE: one cycle with `wr_en`=1, `wr_addr`=window index, `wr_data`=latched value. Then advance c.
  - If c wraps at IMG_W/2, advance r.
  - If r wraps at IMG_H/2, go to DONE; otherwise go to FETCH.
- DONE: `done`=1 for one cycle, `busy`←0, go to IDLE.
- Odd dimensions: the trailing column/row is never read (floor division).
- `start` while `busy`: ignored.
- `mp_finish` in any state other than WAIT sets `err` and is otherwise ignored.
- Values pass through unmodified; the block does no arithmetic on data.

## Timing
- Per window: 4 FETCH + 1 DRAIN + L WAIT + 1 WRITE cycles, where L ≥ 1 is the maxpool latency from `mp_end` to `mp_finish`.
- `mp_finish` in the same cycle as `mp_end` is illegal and flagged by `err`.
- Frame time: 1 CLR + N·(6+L) + 1 DONE cycles, with N = (IMG_W/2)(IMG_H/2).
- Pixel ordering relative to `mp_end`:
  - The cycle after `start` is accepted is CLR.
  - The first `rd_en` is 2 cycles after `start`.
  - The first `mp_data` is 3 cycles after `start`.
  - `mp_end` falls on the 4th `mp_data` cycle.
- `wr_en` is asserted the cycle after `mp_finish` is sampled.
- `done` is asserted the cycle after the final `wr_en`.
- `start` coincident with `done` is ignored (not IDLE yet). A `start` on the next cycle is accepted.

## Structure
- Shared package `bcnn_pkg` holds:
  - `pix_t` (logic [11:0], Q4.8).
  - `FRAC_BITS`=8.
  - The state enum `mpc_state_e`.
- Optional sub-module `win_addr_gen`: window counters, row base, 4-step address sequencer and wrap flags. The FSM and the data/write path stay in `maxpool_ctrl`.

## Test plan
- 4×4 map, pixels 0x010…0x100 row-major; behavioural maxpool (max, L=2) → 4 writes at addresses 0–3 = 0x060, 0x080, 0x0E0, 0x100; `done` at cycle 1+4·8+1.
- Address order: window (1,1) of 4×4 → `rd_addr` sequence 10, 11, 14, 15; `mp_end` high only with the pixel from address 15.
- 5×3 map → exactly 2 windows; rows 2 and column 4 never read; `wr_addr` 0,1.
- Reset (`rst`=0) held 1 cycle during WAIT of window 2 → all outputs 0 next cycle, no `wr_en`. A new `start` then rewrites from address 0.
- Spurious `mp_finish` during FETCH → `err`=1 and sticky; frame still completes with correct data; next `start` clears `err`.
- `start` pulsed while `busy` and coincident with `done` → ignored; write count unchanged.
